// File: rtl/fetch_ctrl.sv
// Dual-issue fetch sequencer: owns the fetch PC, drives the synchronous pair ROM,
// buffers returned instruction pairs and hands them to decode over valid/ready.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2,
   parameter int          ROM_AW   = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [31:0]       rom_instr1,
   input  logic [31:0]       rom_instr2,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_pc,
   output logic [31:0]       out_instr1,
   output logic [31:0]       out_instr2,
   output logic              out_valid2,
   output logic              misalign_err
);

   localparam int          PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int          CW  = $clog2(DEPTH + 1);
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]   issue_pc;
   logic [31:0]   inflight_pc;
   logic          inflight;
   logic          inflight_last;
   logic [31:0]   fetch_pc;
   logic          last;
   logic          issue;
   logic          push;
   logic          pop;
   logic [CW:0]   occ;

   logic [31:0]   mem_pc [DEPTH];
   logic [31:0]   mem_i1 [DEPTH];
   logic [31:0]   mem_i2 [DEPTH];
   logic          mem_v2 [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;

   // A redirect steers the ROM address in the same cycle so the new target is fetched on that edge.
   assign fetch_pc = redirect_valid ? {redirect_pc[31:2], 2'b00} : issue_pc;
   assign rom_addr = fetch_pc[ROM_AW+1:2];
   assign last     = &rom_addr;

   assign out_valid  = (count != '0) && !redirect_valid;
   assign pop        = out_valid && out_ready;
   assign push       = inflight && !redirect_valid;
   assign occ        = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
   assign issue      = redirect_valid || (occ < (CW+1)'(DEPTH));

   assign out_pc     = mem_pc[rd_ptr];
   assign out_instr1 = mem_i1[rd_ptr];
   assign out_instr2 = mem_i2[rd_ptr];
   assign out_valid2 = out_valid && mem_v2[rd_ptr];

   function automatic logic [PW-1:0] ptrNext(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_pc      <= RESET_PC;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         inflight_pc   <= '0;
         misalign_err  <= 1'b0;
      end else begin
         misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
         inflight     <= issue;
         if (issue) begin
            inflight_last <= last;
            inflight_pc   <= fetch_pc;
            issue_pc      <= fetch_pc + (last ? 32'd4 : 32'd8);
         end
      end
   end

   // Pair FIFO; a redirect drops everything queued and the killed read is never pushed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_pc[i] <= '0;
            mem_i1[i] <= NOP;
            mem_i2[i] <= NOP;
            mem_v2[i] <= 1'b0;
         end
      end else if (redirect_valid) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem_pc[wr_ptr] <= inflight_pc;
            mem_i1[wr_ptr] <= rom_instr1;
            mem_i2[wr_ptr] <= rom_instr2;
            mem_v2[wr_ptr] <= !inflight_last;
            wr_ptr         <= ptrNext(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptrNext(rd_ptr);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !pop && (count == CW'(DEPTH))));

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Dual-issue fetch sequencer sitting between the PC/redirect logic and the dual-output instruction ROM.
- The ROM is synchronous: one registered read per clock, returning word[addr] and word[addr+1].
- This block:
  - owns the fetch PC and drives the ROM word address;
  - tracks the one-cycle in-flight read;
  - buffers returned pairs in a small FIFO and presents them to decode over a valid/ready handshake;
  - discards stale fetches on branch/jump redirect.

Parameters:
- RESET_PC, 32'h0000_0000, byte PC fetched first after reset.
- DEPTH, 2, fetch-pair FIFO entries (min 2).
- ROM_AW, 10, ROM word-address width. ROM holds 2^ROM_AW words.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rom_addr  out  ROM_AW  word address to ROM = issue_pc[ROM_AW+1:2]; combinational (see redirect).
- rom_instr1  in  32  ROM word[addr], valid the cycle after issue.
- rom_instr2  in  32  ROM word[addr+1], valid the cycle after issue.
- redirect_valid  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  32  redirect target byte PC.
- out_valid  out  1  FIFO head pair available.
- out_ready  in  1  decode accepts head pair.
- out_pc  out  32  byte PC of out_instr1.
- out_instr1  out  32  first instruction of pair.
- out_instr2  out  32  second instruction of pair.
- out_valid2  out  1  out_instr2 is usable.
- misalign_err  out  1  one-cycle pulse: redirect_pc[1:0] != 0.

Behaviour:
- Reset (async, rst_n low):
  - issue_pc = RESET_PC; inflight = 0; FIFO empty.
  - out_valid = 0, out_valid2 = 0, out_pc = 0, misalign_err = 0.
  - out_instr1 = out_instr2 = 32'h0000_0013 (NOP).
  - rom_addr = RESET_PC[ROM_AW+1:2].
- Last-word rule: last = (issue_pc[ROM_AW+1:2] == all-ones).
- Issue rule: issue = (fifo_count + inflight - pop) < DEPTH, where pop = out_valid & out_ready.
- On an issue edge (no redirect):
  - inflight <= 1; inflight_last <= last; inflight_pc <= issue_pc.
  - issue_pc <= issue_pc + (last ? 4 : 8). The 32-bit add wraps naturally, so rom_addr wraps to 0.
- If no issue: inflight <= 0, and rom_addr holds its value.
- Return: in any cycle with inflight = 1 and no redirect, the next edge pushes {inflight_pc, rom_instr1, rom_instr2, valid2 = ~inflight_last} into the FIFO.
  - The issue rule guarantees the FIFO never overflows. Overflow is an assertion failure.
- Latency: request issued at edge E0; pair is pushed at E1; out_valid is high the cycle after E1. Minimum 2 edges from address to out_valid.
- Throughput: with out_ready held high, one pair per clock in steady state.
- Pop at an edge: head dequeued. A push and a pop on the same edge are both honoured.
- Output registers show the FIFO head. When empty: out_valid = 0, and instr outputs hold the last value (don't-care).
- Redirect (redirect_valid high at an edge): takes priority over everything else.
  - FIFO cleared; the in-flight read is killed, so its data is never pushed.
  - In the same cycle, rom_addr = redirect_pc[ROM_AW+1:2] (combinational mux), and an issue occurs on that edge.
  - inflight_pc = {redirect_pc[31:2], 2'b00}; issue_pc advances from the aligned target per the last-word rule.
  - out_valid is forced low while redirect_valid is high, so no pop can occur in a redirect cycle.
- Misaligned redirect (redirect_pc[1:0] != 0):
  - Low bits ignored; fetch proceeds from the aligned PC.
  - misalign_err = 1 for the cycle after the edge, otherwise 0.
- Back-to-back redirects: each one overrides the previous; only the final target's pairs appear.
- Reset asserted mid-operation: everything returns to reset values immediately (async). Any ROM data arriving afterwards is ignored.

Test Plan:
- Reset release, out_ready=1, ROM model word[i]=i → out_pc 0,8,16,24 on consecutive cycles; instr1/instr2 = 0/1, 2/3, 4/5; first out_valid after 2nd edge.
- Backpressure: out_ready=0 for 6 cycles after 1st valid → FIFO holds 2 pairs; rom_addr stable; no issue. Release → pcs 0,8,16 in order, no loss or duplication.
- Redirect to 0x40 while FIFO full and a read in flight → out_valid low during redirect cycle; next out_pc = 0x40 with instr 16/17; no pair from before the redirect appears.
- Redirect to 0xFFC (ROM_AW=10) → pair pc 0xFFC with out_valid2 = 0; next pair pc 0x1000, rom_addr = 0, instr 0/1.
- Redirect to 0x22 → misalign_err pulses one cycle; out_pc = 0x20.
- rst_n low while streaming at pc 0x30 → out_valid drops immediately; after release, fetch restarts at RESET_PC.
